// File: rtl/exe_wb_result_arbiter.sv
// Merges a buffered single-cycle ALU result stream and one mul/div holding
// register onto a single valid/ready writeback port.
module exe_wb_result_arbiter #(
  parameter int ALU_DEPTH  = 4,
  parameter int TAG_W      = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             alu_valid_i,
  output logic             alu_ready_o,
  input  logic [4:0]       alu_rd_i,
  input  logic [63:0]      alu_result_i,
  input  logic [TAG_W-1:0] alu_tag_i,
  input  logic             mul_valid_i,
  output logic             mul_ready_o,
  input  logic [4:0]       mul_rd_i,
  input  logic [63:0]      mul_result_i,
  input  logic [TAG_W-1:0] mul_tag_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [63:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_src_o
);

  localparam int PTR_W = $clog2(ALU_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int ENT_W = 5 + 64 + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ALU_DEPTH);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  logic [ENT_W-1:0] fifo_mem_q [ALU_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mul_full_q, mul_full_d;
  logic [ENT_W-1:0] mul_ent_q, mul_ent_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             hold_mul_q, hold_mul_d;

  logic             alu_push, mul_push;
  logic             wb_valid, wb_fire, grant_mul;
  logic             alu_pop, mul_pop;
  logic [ENT_W-1:0] wb_ent;

  // hold_mul_q keeps a stalled mul grant from being pre-empted when an ALU
  // result lands in the previously empty FIFO during the stall.
  always_comb begin
    alu_ready_o = (count_q != FULL_CNT);
    mul_ready_o = !mul_full_q;
    alu_push    = alu_valid_i & alu_ready_o & !flush_i;
    mul_push    = mul_valid_i & mul_ready_o & !flush_i;
    wb_valid    = !flush_i & ((count_q != '0) | mul_full_q);
    grant_mul   = mul_full_q & ((count_q == '0) | (starve_q == STV_SAT) | hold_mul_q);
    wb_fire     = wb_valid & wb_ready_i;
    alu_pop     = wb_fire & !grant_mul;
    mul_pop     = wb_fire & grant_mul;
    wb_ent      = grant_mul ? mul_ent_q : fifo_mem_q[head_q];

    wb_valid_o  = wb_valid;
    wb_src_o    = wb_valid & grant_mul;
    {wb_rd_o, wb_result_o, wb_tag_o} = wb_valid ? wb_ent : '0;
  end

  always_comb begin
    head_d     = head_q + PTR_W'(alu_pop);
    tail_d     = tail_q + PTR_W'(alu_push);
    count_d    = count_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
    mul_full_d = mul_full_q;
    mul_ent_d  = mul_ent_q;
    starve_d   = starve_q;
    hold_mul_d = wb_valid & !wb_ready_i & grant_mul;

    if (mul_push) begin
      mul_full_d = 1'b1;
      mul_ent_d  = {mul_rd_i, mul_result_i, mul_tag_i};
    end else if (mul_pop) begin
      mul_full_d = 1'b0;
    end

    if (!mul_full_q || mul_pop) begin
      starve_d = '0;
    end else if (alu_pop && (starve_q != STV_SAT)) begin
      starve_d = starve_q + STV_W'(1);
    end

    // A flush returns every piece of control state to its reset value.
    if (flush_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      mul_full_d = 1'b0;
      starve_d   = '0;
      hold_mul_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mul_full_q <= 1'b0;
      mul_ent_q  <= '0;
      starve_q   <= '0;
      hold_mul_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mul_full_q <= mul_full_d;
      mul_ent_q  <= mul_ent_d;
      starve_q   <= starve_d;
      hold_mul_q <= hold_mul_d;
    end
  end

  // Payload storage needs no reset: it is only visible behind count_q.
  always_ff @(posedge clk_i) begin
    if (alu_push) begin
      fifo_mem_q[tail_q] <= {alu_rd_i, alu_result_i, alu_tag_i};
    end
  end

endmodule

// File: tb/tb_exe_wb_result_arbiter.sv
// Self-checking bench for exe_wb_result_arbiter: a queue scoreboard checks
// every cycle, plus a vector table and directed sequences for corner cases.
module tb_exe_wb_result_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] result;
    logic [5:0]  tag;
  } res_t;

  typedef struct {
    logic       av;
    logic [5:0] atag;
    logic       wrdy;
    logic       exp_ardy;
    logic       exp_wv;
    logic [5:0] exp_tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_result = '0;
  logic [5:0]  alu_tag = '0;
  logic        mul_valid = 1'b0;
  logic        mul_ready;
  logic [4:0]  mul_rd = '0;
  logic [63:0] mul_result = '0;
  logic [5:0]  mul_tag = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [63:0] wb_result;
  logic [5:0]  wb_tag;
  logic        wb_src;

  exe_wb_result_arbiter #(.ALU_DEPTH(4), .TAG_W(6), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd),
    .alu_result_i(alu_result), .alu_tag_i(alu_tag),
    .mul_valid_i(mul_valid), .mul_ready_o(mul_ready), .mul_rd_i(mul_rd),
    .mul_result_i(mul_result), .mul_tag_i(mul_tag),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_result_o(wb_result), .wb_tag_o(wb_tag), .wb_src_o(wb_src)
  );

  always #5 clk = ~clk;

  res_t alu_q[$];
  res_t mul_q[$];
  res_t cur_alu, cur_mul;
  res_t none = '0;
  int   starve = 0;
  bit   hold = 1'b0;
  logic exp_valid, exp_src;
  int   total = 0;
  int   bad = 0;

  function automatic res_t mk(input logic [5:0] tag);
    res_t r;
    r.rd     = tag[4:0] ^ 5'h15;
    r.result = 64'(tag) * 64'h1111;
    r.tag    = tag;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input res_t a, input logic mv, input res_t m,
                               input logic wrdy, input logic fl);
    cur_alu    = a;
    cur_mul    = m;
    alu_valid  = av;
    alu_rd     = a.rd;
    alu_result = a.result;
    alu_tag    = a.tag;
    mul_valid  = mv;
    mul_rd     = m.rd;
    mul_result = m.result;
    mul_tag    = m.tag;
    wb_ready   = wrdy;
    flush      = fl;
  endtask

  // Expected outputs come from the queue model and the starvation counter.
  task automatic checkOutput();
    res_t e;
    exp_valid = !flush && ((alu_q.size() != 0) || (mul_q.size() != 0));
    exp_src   = exp_valid && (mul_q.size() != 0) &&
                ((alu_q.size() == 0) || (starve == 4) || hold);
    check("alu_ready", alu_ready, alu_q.size() != 4);
    check("mul_ready", mul_ready, mul_q.size() == 0);
    check("wb_valid", wb_valid, exp_valid);
    check("wb_src", wb_src, exp_src);
    if (exp_valid) begin
      e = exp_src ? mul_q[0] : alu_q[0];
      check("wb_rd", wb_rd, e.rd);
      check("wb_result", wb_result, e.result);
      check("wb_tag", wb_tag, e.tag);
    end else begin
      check("wb_data_zero", {wb_rd, wb_tag}, '0);
      check("wb_result_zero", wb_result, '0);
    end
  endtask

  task automatic apply_and_check(input logic av, input res_t a, input logic mv, input res_t m,
                                 input logic wrdy, input logic fl);
    applyStimulus(av, a, mv, m, wrdy, fl);
    #2;
    checkOutput();
  endtask

  task automatic clear_model();
    alu_q.delete();
    mul_q.delete();
    starve = 0;
    hold   = 1'b0;
  endtask

  task automatic commit();
    bit alu_pop, mul_pop, alu_push, mul_push, mul_pend;
    if (flush) begin
      clear_model();
    end else begin
      alu_pop  = exp_valid && wb_ready && !exp_src;
      mul_pop  = exp_valid && wb_ready && exp_src;
      alu_push = alu_valid && (alu_q.size() != 4);
      mul_push = mul_valid && (mul_q.size() == 0);
      mul_pend = (mul_q.size() != 0);
      if (!mul_pend || mul_pop) starve = 0;
      else if (alu_pop && starve < 4) starve++;
      hold = exp_valid && !wb_ready && exp_src;
      if (alu_pop) void'(alu_q.pop_front());
      if (mul_pop) void'(mul_q.pop_front());
      if (alu_push) alu_q.push_back(cur_alu);
      if (mul_push) mul_q.push_back(cur_mul);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic wrdy);
    for (int i = 0; i < n; i++) begin
      apply_and_check(1'b0, none, 1'b0, none, wrdy, 1'b0);
      commit();
    end
  endtask

  vec_t t2[11];
  logic [5:0] t3_tag[6];
  logic       t3_src[6];

  initial begin
    int   delivered;
    logic [5:0] last_tag;
    logic [5:0] tag_ctr;
    res_t ra, rm;
    logic av, mv;

    t2[0]  = '{1'b1, 6'd1, 1'b0, 1'b1, 1'b0, 6'd0};
    t2[1]  = '{1'b1, 6'd2, 1'b0, 1'b1, 1'b1, 6'd1};
    t2[2]  = '{1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 6'd1};
    t2[3]  = '{1'b1, 6'd4, 1'b0, 1'b1, 1'b1, 6'd1};
    t2[4]  = '{1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 6'd1};
    t2[5]  = '{1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 6'd1};
    t2[6]  = '{1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 6'd2};
    t2[7]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd3};
    t2[8]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd4};
    t2[9]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd5};
    t2[10] = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd0};
    t3_tag = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd9, 6'd14};
    t3_src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // T1: reset held with valid inputs, then released
    $display("[TB] reset");
    clear_model();
    applyStimulus(1'b1, mk(6'd60), 1'b1, mk(6'd61), 1'b1, 1'b0);
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    applyStimulus(1'b0, none, 1'b0, none, 1'b0, 1'b0);
    rstn = 1'b1;
    #1;
    idle_cycles(2, 1'b0);

    // T2: fill the FIFO under backpressure, then drain in order
    $display("[TB] fifo fill");
    for (int i = 0; i < 11; i++) begin
      apply_and_check(t2[i].av, mk(t2[i].atag), 1'b0, none, t2[i].wrdy, 1'b0);
      check("t2_alu_ready", alu_ready, t2[i].exp_ardy);
      check("t2_wb_valid", wb_valid, t2[i].exp_wv);
      if (t2[i].exp_wv) check("t2_wb_tag", wb_tag, t2[i].exp_tag);
      commit();
    end

    // T3: mul result waits behind a continuous ALU stream
    $display("[TB] starvation");
    apply_and_check(1'b1, mk(6'd10), 1'b1, mk(6'd9), 1'b0, 1'b0);
    commit();
    for (int i = 0; i < 6; i++) begin
      apply_and_check(1'b1, mk(6'(11 + i)), 1'b0, none, 1'b1, 1'b0);
      check("t3_valid", wb_valid, 1'b1);
      check("t3_tag", wb_tag, t3_tag[i]);
      check("t3_src", wb_src, t3_src[i]);
      commit();
    end
    idle_cycles(4, 1'b1);

    // T4: push and pop every cycle across pointer wrap
    $display("[TB] wrap");
    for (int i = 0; i < 21; i++) begin
      apply_and_check(1'b1, mk(6'(20 + i)), 1'b0, none, 1'b1, 1'b0);
      check("t4_alu_ready", alu_ready, 1'b1);
      if (i > 0) check("t4_valid", wb_valid, 1'b1);
      commit();
    end
    idle_cycles(2, 1'b1);

    // T5: flush with buffered entries and a coincident push
    $display("[TB] flush");
    apply_and_check(1'b1, mk(6'd40), 1'b1, mk(6'd43), 1'b0, 1'b0);
    commit();
    apply_and_check(1'b1, mk(6'd41), 1'b0, none, 1'b0, 1'b0);
    commit();
    apply_and_check(1'b1, mk(6'd42), 1'b0, none, 1'b0, 1'b0);
    commit();
    apply_and_check(1'b1, mk(6'd44), 1'b0, none, 1'b1, 1'b1);
    check("t5_flush_valid", wb_valid, 1'b0);
    commit();
    apply_and_check(1'b0, none, 1'b0, none, 1'b1, 1'b0);
    check("t5_after_valid", wb_valid, 1'b0);
    check("t5_after_alu_ready", alu_ready, 1'b1);
    check("t5_after_mul_ready", mul_ready, 1'b1);
    commit();
    apply_and_check(1'b1, mk(6'd45), 1'b0, none, 1'b1, 1'b0);
    commit();
    delivered = 0;
    last_tag  = '0;
    for (int i = 0; i < 4; i++) begin
      apply_and_check(1'b0, none, 1'b0, none, 1'b1, 1'b0);
      if (wb_valid && wb_ready) begin
        delivered++;
        last_tag = wb_tag;
      end
      commit();
    end
    check("t5_deliveries", delivered, 1);
    check("t5_survivor_tag", last_tag, 6'd45);

    // Async reset in the middle of operation discards everything at once
    $display("[TB] mid reset");
    apply_and_check(1'b1, mk(6'd50), 1'b1, mk(6'd51), 1'b0, 1'b0);
    commit();
    apply_and_check(1'b1, mk(6'd52), 1'b0, none, 1'b0, 1'b0);
    commit();
    applyStimulus(1'b0, none, 1'b0, none, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    clear_model();
    checkOutput();
    check("rst_mid_valid", wb_valid, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_cycles(2, 1'b1);

    // T6: random traffic with toggling backpressure
    $display("[TB] random backpressure");
    tag_ctr = 6'd1;
    for (int i = 0; i < 300; i++) begin
      av = ($urandom_range(0, 9) < 6);
      mv = ($urandom_range(0, 9) < 3);
      ra = mk(tag_ctr);
      ra.result = {$urandom, $urandom};
      tag_ctr = tag_ctr + 6'd1;
      rm = mk(tag_ctr);
      rm.result = {$urandom, $urandom};
      tag_ctr = tag_ctr + 6'd1;
      apply_and_check(av, ra, mv, rm, 1'($urandom_range(0, 1)), 1'b0);
      commit();
    end
    idle_cycles(12, 1'b1);
    check("t6_drained", wb_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
